// File: rtl/serial_subtractor_pkg.sv
// Shared definitions for the bit-serial subtractor: FSM encodings and
// the helper that sizes the bit counter from the operand width.
package serial_subtractor_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } state_e;

  localparam int DEFAULT_WIDTH = 4;

  function automatic int cnt_width(input int width);
    return (width > 2) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/serial_subtractor_if.sv
// Start/done request bus between a sequencing datapath (master) and the
// serial subtractor (slave).
interface serial_subtractor_if #(
  parameter int WIDTH = 4
) ();

  logic             Start;
  logic [WIDTH-1:0] A;
  logic [WIDTH-1:0] B;
  logic             Bin;
  logic             Busy;
  logic             Done;
  logic [WIDTH-1:0] D;
  logic             Bout;

  modport master (
    output Start, A, B, Bin,
    input  Busy, Done, D, Bout
  );

  modport slave (
    input  Start, A, B, Bin,
    output Busy, Done, D, Bout
  );

endinterface

// File: rtl/serial_subtractor_full_subtractor.sv
// Combinational one-bit full-subtractor cell: D = A - B - Bin with borrow-out.
module full_subtractor (
  input  logic A,
  input  logic B,
  input  logic Bin,
  output logic D,
  output logic Bout
);

  assign D    = A ^ B ^ Bin;
  assign Bout = (~A & B) | (~(A ^ B) & Bin);

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial WIDTH-bit subtractor: one full-subtractor cell reused LSB first,
// borrow carried in a register, result published on D/Bout when Done pulses.
module serial_subtractor
  import serial_subtractor_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic                CLK,
  input  logic                RST_N,
  serial_subtractor_if.slave  bus
);

  localparam int CW = cnt_width(WIDTH);

  state_e           state_q, state_d;
  logic [WIDTH-1:0] opa_q, opa_d;
  logic [WIDTH-1:0] opb_q, opb_d;
  logic [WIDTH-2:0] res_q, res_d;
  logic [WIDTH-1:0] d_q, d_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             br_q, br_d;
  logic             bout_q, bout_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             cell_d_s;
  logic             cell_bout_s;
  logic [WIDTH-1:0] res_cat_s;

  full_subtractor u_cell (
    .A    (opa_q[0]),
    .B    (opb_q[0]),
    .Bin  (br_q),
    .D    (cell_d_s),
    .Bout (cell_bout_s)
  );

  // Working result holds the WIDTH-1 bits already produced; this cycle's bit
  // joins as the MSB, so on the last bit the concatenation is the full answer.
  assign res_cat_s = {cell_d_s, res_q};

  // State and datapath registers
  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q <= ST_IDLE;
      opa_q   <= '0;
      opb_q   <= '0;
      res_q   <= '0;
      d_q     <= '0;
      cnt_q   <= '0;
      br_q    <= 1'b0;
      bout_q  <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      opa_q   <= opa_d;
      opb_q   <= opb_d;
      res_q   <= res_d;
      d_q     <= d_d;
      cnt_q   <= cnt_d;
      br_q    <= br_d;
      bout_q  <= bout_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  // Next-state, operand shifting and result capture
  always_comb begin
    state_d = state_q;
    opa_d   = opa_q;
    opb_d   = opb_q;
    res_d   = res_q;
    d_d     = d_q;
    cnt_d   = cnt_q;
    br_d    = br_q;
    bout_d  = bout_q;

    case (state_q)
      ST_IDLE, ST_DONE: begin
        if (bus.Start) begin
          opa_d   = bus.A;
          opb_d   = bus.B;
          br_d    = bus.Bin;
          res_d   = '0;
          cnt_d   = '0;
          state_d = ST_SHIFT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_SHIFT: begin
        opa_d = {1'b0, opa_q[WIDTH-1:1]};
        opb_d = {1'b0, opb_q[WIDTH-1:1]};
        res_d = res_cat_s[WIDTH-1:1];
        br_d  = cell_bout_s;
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CW'(WIDTH - 1)) begin
          d_d     = res_cat_s;
          bout_d  = cell_bout_s;
          state_d = ST_DONE;
        end else begin
          state_d = ST_SHIFT;
        end
      end
      default: begin
        state_d = ST_IDLE;
      end
    endcase

    busy_d = (state_d == ST_SHIFT);
    done_d = (state_d == ST_DONE);
  end

  assign bus.Busy = busy_q;
  assign bus.Done = done_q;
  assign bus.D    = d_q;
  assign bus.Bout = bout_q;

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor: WIDTH=4 directed scenarios and
// WIDTH=8 random vectors, results checked through a scoreboard queue.
module tb_serial_subtractor;

  logic CLK = 1'b0;
  logic RST_N;

  serial_subtractor_if #(.WIDTH(4)) if4 ();
  serial_subtractor_if #(.WIDTH(8)) if8 ();

  serial_subtractor #(.WIDTH(4)) u_dut4 (.CLK(CLK), .RST_N(RST_N), .bus(if4));
  serial_subtractor #(.WIDTH(8)) u_dut8 (.CLK(CLK), .RST_N(RST_N), .bus(if8));

  always #5 CLK = ~CLK;

  int checks   = 0;
  int failures = 0;

  logic [4:0] q4[$];
  logic [8:0] q8[$];

  task automatic start4(input logic [3:0] a, input logic [3:0] b, input logic bin);
    @(negedge CLK);
    if4.A = a; if4.B = b; if4.Bin = bin; if4.Start = 1'b1;
    q4.push_back({1'b0, a} - {1'b0, b} - {4'b0, bin});
    @(negedge CLK);
    if4.Start = 1'b0;
  endtask

  task automatic start8(input logic [7:0] a, input logic [7:0] b, input logic bin);
    @(negedge CLK);
    if8.A = a; if8.B = b; if8.Bin = bin; if8.Start = 1'b1;
    q8.push_back({1'b0, a} - {1'b0, b} - {8'b0, bin});
    @(negedge CLK);
    if8.Start = 1'b0;
  endtask

  // Waits (bounded) for Done on the 4-bit DUT, counting cycles and Busy cycles.
  task automatic wait4(output int lat, output int busy_n, output logic [4:0] got,
                       output logic held);
    logic [4:0] prev;
    prev = {if4.Bout, if4.D};
    held = 1'b1; lat = 0; busy_n = 0;
    while (lat < 40 && if4.Done !== 1'b1) begin
      if (if4.Busy === 1'b1) busy_n++;
      if ({if4.Bout, if4.D} !== prev) held = 1'b0;
      @(negedge CLK);
      lat++;
    end
    got = {if4.Bout, if4.D};
  endtask

  task automatic wait8(output int lat, output logic [8:0] got);
    lat = 0;
    while (lat < 40 && if8.Done !== 1'b1) begin
      @(negedge CLK);
      lat++;
    end
    got = {if8.Bout, if8.D};
  endtask

  task automatic test_reset();
    RST_N = 1'b0;
    if4.Start = 1'b0; if4.A = '0; if4.B = '0; if4.Bin = 1'b0;
    if8.Start = 1'b0; if8.A = '0; if8.B = '0; if8.Bin = 1'b0;
    #12;
    checks++;
    if ({if4.Busy, if4.Done, if4.Bout, if4.D} !== 7'd0) begin
      failures++;
      $display("FAIL reset4: got %b required 0000000", {if4.Busy, if4.Done, if4.Bout, if4.D});
    end
    checks++;
    if ({if8.Busy, if8.Done, if8.Bout, if8.D} !== 11'd0) begin
      failures++;
      $display("FAIL reset8: got %b required 0", {if8.Busy, if8.Done, if8.Bout, if8.D});
    end
    @(negedge CLK);
    RST_N = 1'b1;
    @(negedge CLK);
    checks++;
    if ({if4.Busy, if4.Done, if4.Bout, if4.D} !== 7'd0) begin
      failures++;
      $display("FAIL reset4_release: got %b required 0000000", {if4.Busy, if4.Done, if4.Bout, if4.D});
    end
  endtask

  task automatic test_subtract();
    logic [3:0] ta[5] = '{4'd9, 4'd3, 4'd0, 4'd15, 4'd0};
    logic [3:0] tb[5] = '{4'd3, 4'd9, 4'd0, 4'd15, 4'd1};
    logic       tc[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 1'b0};
    logic [4:0] te[5] = '{5'b0_0110, 5'b1_1010, 5'b1_1111, 5'b0_0000, 5'b1_1111};
    int lat, busy_n;
    logic [4:0] got, exp;
    logic held;
    for (int i = 0; i < 5; i++) begin
      start4(ta[i], tb[i], tc[i]);
      wait4(lat, busy_n, got, held);
      exp = q4.pop_front();
      checks++;
      if (lat !== 4) begin
        failures++;
        $display("FAIL latency vec%0d: got %0d cycles required 4", i, lat);
      end
      checks++;
      if (busy_n !== 4) begin
        failures++;
        $display("FAIL busy_cycles vec%0d: got %0d required 4", i, busy_n);
      end
      checks++;
      if (held !== 1'b1) begin
        failures++;
        $display("FAIL d_hold vec%0d: D/Bout changed before Done", i);
      end
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL result vec%0d: got %b required %b", i, got, exp);
      end
      checks++;
      if (got !== te[i]) begin
        failures++;
        $display("FAIL table vec%0d: got %b required %b", i, got, te[i]);
      end
      @(negedge CLK);
      checks++;
      if (if4.Done !== 1'b0 || {if4.Bout, if4.D} !== got) begin
        failures++;
        $display("FAIL done_fall vec%0d: Done=%b D/Bout=%b required 0 and %b",
                 i, if4.Done, {if4.Bout, if4.D}, got);
      end
    end
  endtask

  task automatic test_start_in_shift();
    int lat, busy_n, pulses;
    logic [4:0] got, exp;
    logic held;
    start4(4'd9, 4'd3, 1'b0);
    @(negedge CLK);
    if4.A = 4'd1; if4.B = 4'd1; if4.Bin = 1'b0; if4.Start = 1'b1;
    @(negedge CLK);
    if4.Start = 1'b0;
    wait4(lat, busy_n, got, held);
    exp = q4.pop_front();
    checks++;
    if (lat !== 2) begin
      failures++;
      $display("FAIL shift_start_latency: got %0d remaining cycles required 2", lat);
    end
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL shift_start_result: got %b required %b", got, exp);
    end
    pulses = 0;
    for (int i = 0; i < 10; i++) begin
      @(negedge CLK);
      if (if4.Done === 1'b1 || if4.Busy === 1'b1) pulses++;
    end
    checks++;
    if (pulses !== 0) begin
      failures++;
      $display("FAIL shift_start_extra: got %0d extra active cycles required 0", pulses);
    end
  endtask

  task automatic test_back_to_back();
    int lat, busy_n;
    logic [4:0] got, exp;
    logic held;
    logic [3:0] a, b;
    logic bin;
    a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); bin = 1'($urandom_range(0, 1));
    @(negedge CLK);
    if4.A = a; if4.B = b; if4.Bin = bin; if4.Start = 1'b1;
    q4.push_back({1'b0, a} - {1'b0, b} - {4'b0, bin});
    @(negedge CLK);
    for (int i = 0; i < 6; i++) begin
      if (i < 5) begin
        a = 4'($urandom_range(0, 15)); b = 4'($urandom_range(0, 15)); bin = 1'($urandom_range(0, 1));
        if4.A = a; if4.B = b; if4.Bin = bin;
        q4.push_back({1'b0, a} - {1'b0, b} - {4'b0, bin});
      end else begin
        if4.Start = 1'b0;
      end
      wait4(lat, busy_n, got, held);
      exp = q4.pop_front();
      checks++;
      if (lat !== 4) begin
        failures++;
        $display("FAIL b2b_latency res%0d: got %0d required 4", i, lat);
      end
      checks++;
      if (got !== exp) begin
        failures++;
        $display("FAIL b2b_result res%0d: got %b required %b", i, got, exp);
      end
      if (i < 5) @(negedge CLK);
    end
    @(negedge CLK);
    checks++;
    if (q4.size() !== 0 || if4.Done !== 1'b0) begin
      failures++;
      $display("FAIL b2b_drain: queue=%0d Done=%b required 0 and 0", q4.size(), if4.Done);
    end
  endtask

  task automatic test_reset_mid();
    int lat, busy_n;
    logic [4:0] got, exp;
    logic held;
    start4(4'd9, 4'd3, 1'b0);
    wait4(lat, busy_n, got, held);
    void'(q4.pop_front());
    start4(4'd12, 4'd5, 1'b0);
    @(negedge CLK);
    RST_N = 1'b0;
    #1;
    checks++;
    if ({if4.Busy, if4.Done, if4.Bout, if4.D} !== 7'd0) begin
      failures++;
      $display("FAIL reset_mid: got %b required 0000000", {if4.Busy, if4.Done, if4.Bout, if4.D});
    end
    q4.delete();
    @(negedge CLK);
    RST_N = 1'b1;
    start4(4'd12, 4'd5, 1'b0);
    wait4(lat, busy_n, got, held);
    exp = q4.pop_front();
    checks++;
    if (got !== exp || lat !== 4) begin
      failures++;
      $display("FAIL reset_mid_restart: got %b in %0d cycles required %b in 4", got, lat, exp);
    end
  endtask

  task automatic test_random8();
    int lat;
    logic [8:0] got, exp;
    for (int i = 0; i < 1000; i++) begin
      start8(8'($urandom_range(0, 255)), 8'($urandom_range(0, 255)), 1'($urandom_range(0, 1)));
      wait8(lat, got);
      exp = q8.pop_front();
      checks++;
      if (got !== exp || lat !== 8) begin
        failures++;
        $display("FAIL random8 vec%0d: got %b in %0d cycles required %b in 8", i, got, lat, exp);
      end
    end
  endtask

  initial begin
    test_reset();
    test_subtract();
    test_start_in_shift();
    test_back_to_back();
    test_reset_mid();
    test_random8();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
